// File: rtl/clasificador_vc.sv
// Steers each word to the VC0/VC1 FIFO by its class bit; push is visible 2 cycles after valid_in.
// Backpressure: a held word blocked by its target almost_full drops ready_out and raises pause_out.
module clasificador_vc #(
   parameter int DATA_W  = 6,
   parameter int VC_BIT  = 5,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset_L,
   input  logic [DATA_W-1:0]  data_in,
   input  logic               valid_in,
   output logic               ready_out,
   input  logic               VC0_almost_full,
   input  logic               VC1_almost_full,
   output logic               VC0_push,
   output logic [DATA_W-1:0]  VC0_data,
   output logic               VC1_push,
   output logic [DATA_W-1:0]  VC1_data,
   output logic               pause_out,
   output logic [COUNT_W-1:0] cnt_vc0,
   output logic [COUNT_W-1:0] cnt_vc1
);

   typedef enum logic [1:0] {IDLE, LOADED, PAUSE} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_v, tgt, af_tgt, af_new, drain, accept;

   // The FSM doubles as the hold-valid flag: any non-IDLE state has a word held.
   assign hold_v    = (state_q != IDLE);
   assign tgt       = hold_q[VC_BIT];
   assign af_tgt    = tgt ? VC1_almost_full : VC0_almost_full;
   assign drain     = hold_v & ~af_tgt;
   assign ready_out = ~hold_v | drain;
   assign accept    = valid_in & ready_out;
   assign pause_out = (state_q == PAUSE);

   always_comb begin
      hold_d  = hold_q;
      state_d = state_q;
      if (accept) begin
         hold_d = data_in;
      end
      af_new = hold_d[VC_BIT] ? VC1_almost_full : VC0_almost_full;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = af_new ? PAUSE : LOADED;
            end
         end
         LOADED, PAUSE: begin
            if (accept) begin
               state_d = af_new ? PAUSE : LOADED;
            end else if (drain) begin
               state_d = IDLE;
            end else begin
               state_d = PAUSE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q  <= IDLE;
         hold_q   <= '0;
         VC0_push <= 1'b0;
         VC1_push <= 1'b0;
         VC0_data <= '0;
         VC1_data <= '0;
         cnt_vc0  <= '0;
         cnt_vc1  <= '0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         VC0_push <= drain & ~tgt;
         VC1_push <= drain & tgt;
         if (drain & ~tgt) begin
            VC0_data <= hold_q;
            cnt_vc0  <= cnt_vc0 + COUNT_W'(1);
         end
         if (drain & tgt) begin
            VC1_data <= hold_q;
            cnt_vc1  <= cnt_vc1 + COUNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_clasificador_vc.sv
// Randomized and directed stimulus for clasificador_vc, checked by a push scoreboard and per-cycle flow-control checks.
module tb_clasificador_vc;

   logic       clk = 1'b0;
   logic       reset_L;
   logic [5:0] data_in;
   logic       valid_in;
   logic       ready_out;
   logic       VC0_almost_full, VC1_almost_full;
   logic       VC0_push, VC1_push;
   logic [5:0] VC0_data, VC1_data;
   logic       pause_out;
   logic [7:0] cnt_vc0, cnt_vc1;

   clasificador_vc dut (
      .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
      .ready_out(ready_out), .VC0_almost_full(VC0_almost_full), .VC1_almost_full(VC1_almost_full),
      .VC0_push(VC0_push), .VC0_data(VC0_data), .VC1_push(VC1_push), .VC1_data(VC1_data),
      .pause_out(pause_out), .cnt_vc0(cnt_vc0), .cnt_vc1(cnt_vc1)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] d;
      logic [7:0] c;
      int         due;
   } ev_t;

   ev_t        exp0[$], exp1[$];
   logic [5:0] holdq[$];
   logic [7:0] c0, c1;
   logic [5:0] last0, last1;
   logic       exp_pause;
   int         cyc = 0;
   int         ncmp = 0, nerr = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      ncmp++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
      end
   endtask

   function automatic logic af_of(input logic [5:0] w);
      return w[5] ? VC1_almost_full : VC0_almost_full;
   endfunction

   // Monitor: an expected push is due at exactly one edge; anything else is a spurious push.
   task automatic mon(input int vc, input logic push, input logic [5:0] data, input logic [7:0] cnt);
      ev_t e;
      bit  have;
      have = 0;
      if (vc == 0 && exp0.size() > 0 && exp0[0].due == cyc) begin e = exp0.pop_front(); have = 1; end
      if (vc == 1 && exp1.size() > 0 && exp1[0].due == cyc) begin e = exp1.pop_front(); have = 1; end
      if (have) begin
         chk($sformatf("vc%0d push", vc), {push, data, cnt}, {1'b1, e.d, e.c});
         if (vc == 0) last0 = e.d; else last1 = e.d;
      end else begin
         chk($sformatf("vc%0d idle", vc), {push, data}, {1'b0, (vc == 0) ? last0 : last1});
      end
   endtask

   always @(negedge clk) begin
      if (reset_L === 1'b1) begin
         mon(0, VC0_push, VC0_data, cnt_vc0);
         mon(1, VC1_push, VC1_data, cnt_vc1);
      end
   end

   task automatic model_clear();
      exp0.delete(); exp1.delete(); holdq.delete();
      c0 = 0; c1 = 0; last0 = 0; last1 = 0; exp_pause = 0;
   endtask

   // Entered at posedge+1: drive, check flow control at negedge, advance the model, return at posedge+1.
   task automatic step(input logic v, input logic [5:0] d, input logic a0, input logic a1);
      logic       rdy;
      logic [5:0] w;
      valid_in = v; data_in = d; VC0_almost_full = a0; VC1_almost_full = a1;
      @(negedge clk);
      rdy = (holdq.size() == 0) || !af_of(holdq[0]);
      chk("ready_out", ready_out, rdy);
      chk("pause_out", pause_out, exp_pause);
      if (holdq.size() > 0 && !af_of(holdq[0])) begin
         w = holdq.pop_front();
         if (w[5]) begin c1 = c1 + 1; exp1.push_back('{w, c1, cyc + 1}); end
         else      begin c0 = c0 + 1; exp0.push_back('{w, c0, cyc + 1}); end
      end
      if (v && rdy) holdq.push_back(d);
      exp_pause = (holdq.size() > 0) && af_of(holdq[0]);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_L = 1'b0; valid_in = 1'b0;
      model_clear();
      #1;
      chk("rst push", {VC0_push, VC1_push}, 2'b00);
      chk("rst data", {VC0_data, VC1_data}, 12'h000);
      chk("rst cnt", {cnt_vc0, cnt_vc1}, 16'h0000);
      chk("rst pause/ready", {pause_out, ready_out}, 2'b01);
      @(posedge clk);
      #1;
      reset_L = 1'b1;
   endtask

   initial begin
      reset_L = 1'b0; valid_in = 1'b0; data_in = '0;
      VC0_almost_full = 1'b0; VC1_almost_full = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Mixed-VC stream at full rate
      step(1, 6'h21, 0, 0); step(1, 6'h05, 0, 0); step(1, 6'h3F, 0, 0);
      repeat (3) step(0, 6'h00, 0, 0);
      chk("cnt after stream", {cnt_vc0, cnt_vc1}, {8'd1, 8'd2});

      // Held word paused by its own VC
      step(1, 6'h0A, 1, 0);
      repeat (5) step(0, 6'h00, 1, 0);
      chk("pause held", {pause_out, ready_out}, 2'b10);
      repeat (3) step(0, 6'h00, 0, 0);

      // The other VC's almost_full must not stall
      step(1, 6'h2C, 1, 0);
      repeat (3) step(0, 6'h00, 1, 0);
      step(0, 6'h00, 0, 0);

      // Both flags high: one word accepted, then paused
      step(1, 6'h13, 1, 1); step(1, 6'h33, 1, 1); step(1, 6'h33, 1, 1);
      repeat (3) step(1, 6'h33, 0, 0);
      repeat (2) step(0, 6'h00, 0, 0);

      // Mid-stream reset
      step(1, 6'h07, 0, 0); step(1, 6'h27, 0, 0);
      do_reset();
      repeat (2) step(0, 6'h00, 0, 0);

      // Random traffic
      for (int i = 0; i < 600; i++)
         step(($urandom % 4) != 0, 6'($urandom), ($urandom % 4) == 0, ($urandom % 5) == 0);
      repeat (3) step(0, 6'h00, 0, 0);

      // Counter wrap on VC0
      do_reset();
      for (int i = 0; i < 256; i++) step(1, 6'($urandom_range(0, 31)), 0, 0);
      repeat (3) step(0, 6'h00, 0, 0);
      chk("cnt wrap", {cnt_vc0, cnt_vc1}, 16'h0000);

      // Reset while paused discards the held word
      step(1, 6'h11, 1, 0);
      repeat (3) step(0, 6'h00, 1, 0);
      chk("paused before reset", pause_out, 1'b1);
      do_reset();
      repeat (5) step(0, 6'h00, 0, 0);
      chk("idle after reset", {pause_out, ready_out, cnt_vc0}, {2'b01, 8'h00});

      chk("final cnt", {cnt_vc0, cnt_vc1}, {c0, c1});
      chk("scoreboard drained", exp0.size() + exp1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
